// File: rtl/revive_fetch_ahbl_adapter_if.sv
// Bundle of fetch-side request/response signals and AHB-Lite master signals for the fetch adapter.
// REVIVE_FETCH_ERR_EN adds mem_data_err to the bundle.
interface revive_fetch_ahbl_adapter_if #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
) ();
   logic [W_ADDR-1:0] mem_addr;
   logic              mem_addr_vld;
   logic [W_DATA-1:0] mem_data;
   logic              mem_data_vld;
   logic              mem_req_replaces_last;
`ifdef REVIVE_FETCH_ERR_EN
   logic              mem_data_err;
`endif
   logic [W_ADDR-1:0] ahblm_haddr;
   logic [1:0]        ahblm_htrans;
   logic              ahblm_hwrite;
   logic [2:0]        ahblm_hsize;
   logic [2:0]        ahblm_hburst;
   logic [3:0]        ahblm_hprot;
   logic              ahblm_hmastlock;
   logic              ahblm_hready;
   logic              ahblm_hresp;
   logic [W_DATA-1:0] ahblm_hrdata;

`ifdef REVIVE_FETCH_ERR_EN
   modport master (
      input  mem_addr, mem_addr_vld, ahblm_hready, ahblm_hresp, ahblm_hrdata,
      output mem_data, mem_data_vld, mem_req_replaces_last, mem_data_err,
             ahblm_haddr, ahblm_htrans, ahblm_hwrite, ahblm_hsize, ahblm_hburst,
             ahblm_hprot, ahblm_hmastlock
   );
   modport slave (
      output mem_addr, mem_addr_vld, ahblm_hready, ahblm_hresp, ahblm_hrdata,
      input  mem_data, mem_data_vld, mem_req_replaces_last, mem_data_err,
             ahblm_haddr, ahblm_htrans, ahblm_hwrite, ahblm_hsize, ahblm_hburst,
             ahblm_hprot, ahblm_hmastlock
   );
`else
   modport master (
      input  mem_addr, mem_addr_vld, ahblm_hready, ahblm_hresp, ahblm_hrdata,
      output mem_data, mem_data_vld, mem_req_replaces_last,
             ahblm_haddr, ahblm_htrans, ahblm_hwrite, ahblm_hsize, ahblm_hburst,
             ahblm_hprot, ahblm_hmastlock
   );
   modport slave (
      output mem_addr, mem_addr_vld, ahblm_hready, ahblm_hresp, ahblm_hrdata,
      input  mem_data, mem_data_vld, mem_req_replaces_last,
             ahblm_haddr, ahblm_htrans, ahblm_hwrite, ahblm_hsize, ahblm_hburst,
             ahblm_hprot, ahblm_hmastlock
   );
`endif
endinterface

// File: rtl/revive_fetch_ahbl_adapter.sv
// ReVive fetch request -> AHB-Lite read-only master, with a one-deep skid for requests arriving
// while the address phase is stalled. Optional bus-error reporting under REVIVE_FETCH_ERR_EN.
module revive_fetch_ahbl_adapter #(
   parameter int W_ADDR = 32,
   parameter int W_DATA = 32
) (
   input logic                           clk,
   input logic                           rst_n,
   revive_fetch_ahbl_adapter_if.master   bus
);
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   generate
      if (W_DATA != 32) begin : g_bad_width
         $fatal(1, "revive_fetch_ahbl_adapter: W_DATA must be 32");
      end
   endgenerate

   logic              aph_vld_reg;
   logic [W_ADDR-1:0] aph_addr_reg;
   logic              skid_vld_reg;
   logic [W_ADDR-1:0] skid_addr_reg;
   logic              dph_vld_reg;

   logic              adv;
   logic              aph_free;
   logic              skid_load;
   logic [W_ADDR-1:0] req_addr;

   assign req_addr  = {bus.mem_addr[W_ADDR-1:2], 2'b00};
   assign adv       = aph_vld_reg && bus.ahblm_hready;
   assign aph_free  = adv || !aph_vld_reg;
   // A request lands in the skid whenever the address slot will still be busy next cycle:
   // either it is stalled, or it is being refilled from the skid this cycle.
   assign skid_load = bus.mem_addr_vld && (!aph_free || skid_vld_reg);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aph_vld_reg   <= 1'b0;
         aph_addr_reg  <= '0;
         skid_vld_reg  <= 1'b0;
         skid_addr_reg <= '0;
         dph_vld_reg   <= 1'b0;
      end else begin
         if (aph_free) begin
            if (skid_vld_reg) begin
               aph_vld_reg  <= 1'b1;
               aph_addr_reg <= skid_addr_reg;
            end else if (bus.mem_addr_vld) begin
               aph_vld_reg  <= 1'b1;
               aph_addr_reg <= req_addr;
            end else begin
               aph_vld_reg  <= 1'b0;
            end
         end
         if (skid_load) begin
            skid_vld_reg  <= 1'b1;
            skid_addr_reg <= req_addr;
         end else if (aph_free) begin
            skid_vld_reg  <= 1'b0;
         end
         if (bus.ahblm_hready) begin
            dph_vld_reg <= adv;
         end
      end
   end

`ifdef REVIVE_FETCH_ERR_EN
   // Tracks the first cycle of the two-cycle AHB-Lite error response.
   logic err_pending_reg;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_pending_reg <= 1'b0;
      end else if (dph_vld_reg && bus.ahblm_hready) begin
         err_pending_reg <= 1'b0;
      end else if (dph_vld_reg && bus.ahblm_hresp) begin
         err_pending_reg <= 1'b1;
      end
   end
   assign bus.mem_data_err = dph_vld_reg && bus.ahblm_hready && bus.ahblm_hresp;
`endif

   assign bus.mem_data              = bus.ahblm_hrdata;
   assign bus.mem_data_vld          = dph_vld_reg && bus.ahblm_hready;
   assign bus.mem_req_replaces_last = bus.mem_addr_vld && skid_vld_reg && !adv;

   assign bus.ahblm_htrans    = aph_vld_reg ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign bus.ahblm_haddr     = aph_addr_reg;
   assign bus.ahblm_hwrite    = 1'b0;
   assign bus.ahblm_hsize     = 3'b010;
   assign bus.ahblm_hburst    = 3'b000;
   assign bus.ahblm_hprot     = 4'b0010;
   assign bus.ahblm_hmastlock = 1'b0;
endmodule
